issue_queue: RTL

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/issue_queue.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/issue_queue.sv
// 16-entry out-of-order issue queue: dispatch into the lowest free slot, tag wakeup,
// per-entry issue requests, and frees driven by four arbiter grant ports.
module issue_queue #(
    parameter int OPCODE_WIDTH = 7,
    parameter int PRF_WIDTH    = 6,
    parameter int AGE_WIDTH    = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [OPCODE_WIDTH-1:0]    disp_op,
    input  logic [PRF_WIDTH-1:0]       disp_prs1,
    input  logic [PRF_WIDTH-1:0]       disp_prs2,
    input  logic [PRF_WIDTH-1:0]       disp_prd,
    input  logic                       disp_prs1_rdy,
    input  logic                       disp_prs2_rdy,
    input  logic                       disp_prdv,
    input  logic [3:0]                 wb_valid,
    input  logic [4*PRF_WIDTH-1:0]     wb_tag,
    input  logic [3:0]                 gnt_valid,
    input  logic [15:0]                gnt_addr,
    output logic [15:0]                ent_req,
    output logic [16*OPCODE_WIDTH-1:0] ent_op,
    output logic [16*AGE_WIDTH-1:0]    ent_age,
    output logic [16*PRF_WIDTH-1:0]    ent_prs1,
    output logic [16*PRF_WIDTH-1:0]    ent_prs2,
    output logic [16*PRF_WIDTH-1:0]    ent_prd,
    output logic [15:0]                ent_prdv,
    output logic [4:0]                 count
);

    localparam int DEPTH = 16;
    localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

    logic                    valid_reg    [DEPTH];
    logic                    prs1_rdy_reg [DEPTH];
    logic                    prs2_rdy_reg [DEPTH];
    logic                    prdv_reg     [DEPTH];
    logic [OPCODE_WIDTH-1:0] op_reg       [DEPTH];
    logic [PRF_WIDTH-1:0]    prs1_reg     [DEPTH];
    logic [PRF_WIDTH-1:0]    prs2_reg     [DEPTH];
    logic [PRF_WIDTH-1:0]    prd_reg      [DEPTH];
    logic [AGE_WIDTH-1:0]    age_reg      [DEPTH];
    logic [4:0]              count_reg;
    logic [4:0]              count_next;

    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] gnt_mask;
    logic [DEPTH-1:0] free_mask;
    logic [DEPTH-1:0] alloc_onehot;
    logic             alloc_found;
    logic             disp_accept;
    logic             disp_prs1_hit;
    logic             disp_prs2_hit;
    logic [4:0]       freed_cnt;

    function automatic logic tag_hit(
        input logic [PRF_WIDTH-1:0]   tag,
        input logic [3:0]             v,
        input logic [4*PRF_WIDTH-1:0] tags
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (v[k] && (tags[k*PRF_WIDTH +: PRF_WIDTH] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign disp_ready  = (count_reg < 5'd16);
    assign disp_accept = disp_valid && disp_ready && !flush;
    assign count       = count_reg;

    assign disp_prs1_hit = tag_hit(disp_prs1, wb_valid, wb_tag);
    assign disp_prs2_hit = tag_hit(disp_prs2, wb_valid, wb_tag);

    // Duplicate grants collapse into one mask bit, so an entry is freed and counted once.
    always_comb begin
        gnt_mask = '0;
        for (int k = 0; k < 4; k++) begin
            if (gnt_valid[k]) begin
                gnt_mask[gnt_addr[k*4 +: 4]] = 1'b1;
            end
        end
        free_mask = gnt_mask & valid_vec;
    end

    // Allocation looks only at the pre-edge valid vector, so a slot freed this cycle waits.
    always_comb begin
        alloc_onehot = '0;
        alloc_found  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_vec[i] && !alloc_found) begin
                alloc_onehot[i] = 1'b1;
                alloc_found     = 1'b1;
            end
        end
    end

    always_comb begin
        freed_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            freed_cnt = freed_cnt + {4'd0, free_mask[i]};
        end
        count_next = count_reg + {4'd0, disp_accept} - freed_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi]    <= 1'b0;
                    prs1_rdy_reg[gi] <= 1'b0;
                    prs2_rdy_reg[gi] <= 1'b0;
                    prdv_reg[gi]     <= 1'b0;
                    op_reg[gi]       <= '0;
                    prs1_reg[gi]     <= '0;
                    prs2_reg[gi]     <= '0;
                    prd_reg[gi]      <= '0;
                    age_reg[gi]      <= '0;
                end else if (flush) begin
                    valid_reg[gi] <= 1'b0;
                end else if (disp_accept && alloc_onehot[gi]) begin
                    valid_reg[gi]    <= 1'b1;
                    op_reg[gi]       <= disp_op;
                    prs1_reg[gi]     <= disp_prs1;
                    prs2_reg[gi]     <= disp_prs2;
                    prd_reg[gi]      <= disp_prd;
                    prdv_reg[gi]     <= disp_prdv;
                    prs1_rdy_reg[gi] <= disp_prs1_rdy || disp_prs1_hit;
                    prs2_rdy_reg[gi] <= disp_prs2_rdy || disp_prs2_hit;
                    age_reg[gi]      <= '0;
                end else if (valid_reg[gi]) begin
                    if (free_mask[gi]) begin
                        valid_reg[gi] <= 1'b0;
                    end
                    if (age_reg[gi] != AGE_MAX) begin
                        age_reg[gi] <= age_reg[gi] + 1'b1;
                    end
                    if (tag_hit(prs1_reg[gi], wb_valid, wb_tag)) begin
                        prs1_rdy_reg[gi] <= 1'b1;
                    end
                    if (tag_hit(prs2_reg[gi], wb_valid, wb_tag)) begin
                        prs2_rdy_reg[gi] <= 1'b1;
                    end
                end
            end

            assign valid_vec[gi] = valid_reg[gi];
            assign ent_req[gi]   = valid_reg[gi] && prs1_rdy_reg[gi] && prs2_rdy_reg[gi];
            assign ent_prdv[gi]  = prdv_reg[gi];
            assign ent_op[gi*OPCODE_WIDTH +: OPCODE_WIDTH] = op_reg[gi];
            assign ent_age[gi*AGE_WIDTH +: AGE_WIDTH]      = age_reg[gi];
            assign ent_prs1[gi*PRF_WIDTH +: PRF_WIDTH]     = prs1_reg[gi];
            assign ent_prs2[gi*PRF_WIDTH +: PRF_WIDTH]     = prs2_reg[gi];
            assign ent_prd[gi*PRF_WIDTH +: PRF_WIDTH]      = prd_reg[gi];
        end
    endgenerate

endmodule
